// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and helpers for the posted-write store buffer.
//   sb_entry_t : one queued store (word address, lane-aligned data, byte enables)
//   SB_LANES   : byte lanes per data word
//   lane_mask  : expands a 4-bit byte enable into a 32-bit bit mask
package store_buffer_pkg;

  localparam int SB_AW    = 32;
  localparam int SB_LANES = 4;

  typedef struct packed {
    logic [SB_AW-1:2]    waddr;
    logic [31:0]         data;
    logic [SB_LANES-1:0] be;
  } sb_entry_t;

  function automatic logic [31:0] lane_mask(input logic [SB_LANES-1:0] be);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < SB_LANES; l++) begin
      m[l*8 +: 8] = {8{be[l]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: bundles the core-side store/load signals and the
// memory-side write handshake of the store buffer.
//   st_valid/st_addr/st_data/st_be -> store request, st_stall <- refusal
//   ld_valid/ld_addr -> load probe, ld_fwd_be/ld_fwd_data/ld_conflict <- result
//   mem_req/mem_addr/mem_wdata/mem_be <- head entry, mem_ack -> accept
//   empty <- no entries held
// Modports: master = core + memory side, slave = the store buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic                st_valid;
  logic [AW-1:0]       st_addr;
  logic [DW-1:0]       st_data;
  logic [SB_LANES-1:0] st_be;
  logic                st_stall;

  logic                ld_valid;
  logic [AW-1:0]       ld_addr;
  logic [SB_LANES-1:0] ld_fwd_be;
  logic [DW-1:0]       ld_fwd_data;
  logic                ld_conflict;

  logic                mem_req;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [SB_LANES-1:0] mem_be;
  logic                mem_ack;

  logic                empty;

  modport master (
    output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, mem_ack,
    input  st_stall, ld_fwd_be, ld_fwd_data, ld_conflict,
           mem_req, mem_addr, mem_wdata, mem_be, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, mem_ack,
    output st_stall, ld_fwd_be, ld_fwd_data, ld_conflict,
           mem_req, mem_addr, mem_wdata, mem_be, empty
  );

endinterface

// File: rtl/store_buffer_fwd_merge.sv
// sb_fwd_merge: per-byte store-to-load forwarding for the store buffer.
// Walks the held entries from oldest (head) to youngest so that, for every
// byte lane, the youngest matching entry with that lane enabled wins.
//   entries  : entry storage array
//   valid    : which slots currently hold a queued store
//   head     : slot index of the oldest entry
//   ld_addr  : load byte address (word compare only)
//   fwd_be   : lanes supplied by the buffer
//   fwd_data : forwarded bytes, zero in lanes not supplied
// Only built when STORE_BUF_FWD_EN is defined.
`ifdef STORE_BUF_FWD_EN
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [SB_AW-1:0]           ld_addr,
  output logic [SB_LANES-1:0]        fwd_be,
  output logic [31:0]                fwd_data
);

  localparam int PW = $clog2(DEPTH);

  logic unused_ld_lsbs;
  assign unused_ld_lsbs = ^ld_addr[1:0];

  always_comb begin
    logic [PW-1:0] idx;
    logic [31:0]   m;
    fwd_be   = '0;
    fwd_data = '0;
    idx      = '0;
    m        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (entries[idx].waddr == ld_addr[SB_AW-1:2])) begin
        m        = lane_mask(entries[idx].be);
        fwd_be   = fwd_be | entries[idx].be;
        fwd_data = (fwd_data & ~m) | (entries[idx].data & m);
      end
    end
  end

endmodule
`endif

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core data port and a slower,
// handshaked data memory. Stores enter in one cycle and drain strictly in
// order; loads are checked against held stores so no stale data is read.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; discards all entries
//   sb    : store_buffer_if.slave (store, load-check and memory handshake)
// Build option: STORE_BUF_FWD_EN selects per-byte forwarding
// (ld_fwd_be/ld_fwd_data); otherwise a matching load raises ld_conflict.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave sb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sb_entry_t        entries [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             full;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] valid;
  sb_entry_t        head_e;

  // Word-granular buffer: the byte offset bits never matter.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

  assign full = (count == CW'(DEPTH));
  // A full buffer refuses the store even if the head drains on the same edge.
  assign push = sb.st_valid && !full;
  assign pop  = (count != '0) && sb.mem_ack;

  assign sb.st_stall = sb.st_valid && full;
  assign sb.empty    = (count == '0);

  // Memory side comes only from registered state; mem_ack has no path here.
  assign head_e       = entries[head];
  assign sb.mem_req   = (count != '0);
  assign sb.mem_addr  = sb.mem_req ? {head_e.waddr, 2'b00} : '0;
  assign sb.mem_wdata = sb.mem_req ? head_e.data : '0;
  assign sb.mem_be    = sb.mem_req ? head_e.be : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry payload carries no reset; occupancy is tracked by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{waddr: sb.st_addr[AW-1:2], data: sb.st_data, be: sb.st_be};
    end
  end

  // Slot i is held when its distance from head is below count.
  always_comb begin
    logic [PW-1:0] off;
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head;
      valid[i] = (CW'(off) < count);
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [SB_LANES-1:0] fwd_be;
  logic [DW-1:0]       fwd_data;

  sb_fwd_merge #(
    .DEPTH (DEPTH)
  ) u_fwd_merge (
    .entries  (entries),
    .valid    (valid),
    .head     (head),
    .ld_addr  (sb.ld_addr),
    .fwd_be   (fwd_be),
    .fwd_data (fwd_data)
  );

  assign sb.ld_fwd_be   = sb.ld_valid ? fwd_be : '0;
  assign sb.ld_fwd_data = sb.ld_valid ? fwd_data : '0;
  assign sb.ld_conflict = 1'b0;
`else
  logic [DEPTH-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid[i] && (entries[i].waddr == sb.ld_addr[AW-1:2]);
    end
  end

  assign sb.ld_fwd_be   = '0;
  assign sb.ld_fwd_data = {DW{1'b0}};
  assign sb.ld_conflict = sb.ld_valid && (|hit);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer with a queue scoreboard.
// Accepted stores are pushed into a model queue; every memory handshake pops
// the queue and compares. Load results are recomputed from the model queue.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  exp_t q[$];

  store_buffer_if #(.AW(32), .DW(32)) sbif ();

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (32),
    .DW    (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    sbif.st_valid = 1'b1;
    sbif.st_addr  = a;
    sbif.st_data  = d;
    sbif.st_be    = be;
  endtask

  // Scoreboard / reference model, sampled mid-cycle.
  always @(negedge clk) begin
    int          n;
    exp_t        e;
    logic [3:0]  xbe;
    logic [31:0] xd;
    logic        xc;
    if (reset) begin
      q.delete();
      check("rst_mem_req", sbif.mem_req, 0);
      check("rst_empty", sbif.empty, 1);
    end else begin
      n = q.size();
      check("mem_req", sbif.mem_req, (n != 0));
      check("empty", sbif.empty, (n == 0));
      check("st_stall", sbif.st_stall, (sbif.st_valid && n == DEPTH));
      xbe = '0;
      xd  = '0;
      xc  = 1'b0;
      if (sbif.ld_valid) begin
        foreach (q[k]) begin
          if (q[k].addr[31:2] == sbif.ld_addr[31:2]) begin
            xc = 1'b1;
            for (int l = 0; l < 4; l++) begin
              if (q[k].be[l]) begin
                xbe[l]      = 1'b1;
                xd[l*8 +: 8] = q[k].data[l*8 +: 8];
              end
            end
          end
        end
      end
`ifdef STORE_BUF_FWD_EN
      check("ld_fwd_be", sbif.ld_fwd_be, xbe);
      check("ld_fwd_data", sbif.ld_fwd_data, xd);
      check("ld_conflict", sbif.ld_conflict, 0);
`else
      check("ld_fwd_be", sbif.ld_fwd_be, 0);
      check("ld_fwd_data", sbif.ld_fwd_data, 0);
      check("ld_conflict", sbif.ld_conflict, xc);
`endif
      if (n != 0 && sbif.mem_ack) begin
        e = q.pop_front();
        check("mem_addr", sbif.mem_addr, e.addr);
        check("mem_wdata", sbif.mem_wdata, e.data);
        check("mem_be", sbif.mem_be, e.be);
      end
      if (sbif.st_valid && n < DEPTH) begin
        q.push_back('{addr: {sbif.st_addr[31:2], 2'b00}, data: sbif.st_data, be: sbif.st_be});
      end
    end
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    sbif.st_valid = 1'b0;
    sbif.st_addr  = '0;
    sbif.st_data  = '0;
    sbif.st_be    = '0;
    sbif.ld_valid = 1'b0;
    sbif.ld_addr  = '0;
    sbif.mem_ack  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("reset_mem_req", sbif.mem_req, 0);
    check("reset_empty", sbif.empty, 1);
    check("reset_st_stall", sbif.st_stall, 0);
    check("reset_mem_addr", sbif.mem_addr, 0);
    check("reset_ld_fwd_be", sbif.ld_fwd_be, 0);
    check("reset_ld_conflict", sbif.ld_conflict, 0);
    check("reset_count", 32'(dut.count), 0);

    // Single store with mem_ack tied high.
    sbif.mem_ack = 1'b1;
    drive_store(32'hF8, 32'd7, 4'hF);
    tick();
    sbif.st_valid = 1'b0;
    check("single_mem_req", sbif.mem_req, 1);
    check("single_mem_addr", sbif.mem_addr, 32'hF8);
    check("single_mem_wdata", sbif.mem_wdata, 32'd7);
    check("single_mem_be", sbif.mem_be, 4'hF);
    tick();
    check("single_empty", sbif.empty, 1);

    // Fill to DEPTH, the fifth store stalls.
    sbif.mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_store(32'(i * 4), 32'h100 + 32'(i), 4'hF);
      #1;
      check("fill_st_stall", sbif.st_stall, (i == 4));
      tick();
    end
    sbif.st_valid = 1'b0;
    #1;
    check("fill_count", 32'(dut.count), 4);
    check("fill_head_addr", sbif.mem_addr, 32'h0);
    sbif.mem_ack = 1'b1;
    repeat (4) tick();
    check("fill_drained", sbif.empty, 1);

    // Simultaneous push/pop at count 2 across three pointer laps.
    sbif.mem_ack = 1'b0;
    drive_store(32'h200, 32'hA0, 4'hF);
    tick();
    drive_store(32'h204, 32'hA1, 4'hF);
    tick();
    sbif.mem_ack = 1'b1;
    for (int j = 0; j < 12; j++) begin
      drive_store(32'h300 + 32'(j * 4), 32'hB0 + 32'(j), 4'hF);
      tick();
      check("pp_count", 32'(dut.count), 2);
    end
    sbif.st_valid = 1'b0;
    check("pp_head", 32'(dut.head), 1);
    check("pp_tail", 32'(dut.tail), 3);
    repeat (2) tick();
    check("pp_drained", sbif.empty, 1);

    // Load checking against byte and word stores to the same word.
    sbif.mem_ack = 1'b0;
    drive_store(32'h41, 32'h0000AA00, 4'b0010);
    tick();
    drive_store(32'h40, 32'h11223344, 4'hF);
    tick();
    drive_store(32'h42, 32'h00BB0000, 4'b0100);
    tick();
    sbif.st_valid = 1'b0;
    sbif.ld_valid = 1'b1;
    sbif.ld_addr  = 32'h40;
    #1;
`ifdef STORE_BUF_FWD_EN
    check("fwd_be", sbif.ld_fwd_be, 4'hF);
    check("fwd_data", sbif.ld_fwd_data, 32'h11BB3344);
    check("fwd_conflict", sbif.ld_conflict, 0);
`else
    check("nf_conflict", sbif.ld_conflict, 1);
    check("nf_fwd_be", sbif.ld_fwd_be, 0);
`endif
    sbif.ld_addr = 32'h44;
    #1;
    check("miss_conflict", sbif.ld_conflict, 0);
    check("miss_fwd_be", sbif.ld_fwd_be, 0);
    sbif.ld_addr = 32'h40;
    sbif.mem_ack = 1'b1;
    for (int d = 0; d < 3; d++) begin
      tick();
`ifdef STORE_BUF_FWD_EN
      check("drain_fwd_be", sbif.ld_fwd_be, (d == 0) ? 4'hF : (d == 1) ? 4'h4 : 4'h0);
      check("drain_fwd_data", sbif.ld_fwd_data,
            (d == 0) ? 32'h11BB3344 : (d == 1) ? 32'h00BB0000 : 32'h0);
`else
      check("drain_conflict", sbif.ld_conflict, (d < 2));
`endif
    end
    sbif.ld_valid = 1'b0;
    #1;
    check("ld_idle_be", sbif.ld_fwd_be, 0);
    check("ld_idle_conflict", sbif.ld_conflict, 0);

    // Reset with a request outstanding.
    sbif.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h500 + 32'(i * 4), 32'hC0 + 32'(i), 4'hF);
      tick();
    end
    sbif.st_valid = 1'b0;
    check("pre_rst_mem_req", sbif.mem_req, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_mem_req", sbif.mem_req, 0);
    check("mid_rst_empty", sbif.empty, 1);
    check("mid_rst_mem_addr", sbif.mem_addr, 0);
    tick();
    reset = 1'b0;
    sbif.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_mem_req", sbif.mem_req, 0);
    end

    // Spurious acknowledge while empty.
    check("spur_head", 32'(dut.head), 0);
    check("spur_tail", 32'(dut.tail), 0);
    check("spur_count", 32'(dut.count), 0);
    sbif.mem_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's data port and a slower, handshaked data memory. Each store (word or byte) is queued in one cycle, and the queue drains to memory in order. Loads are checked against queued stores so that no stale data is returned. The block sits directly downstream of the core's MemWrite/DataAdr/WriteData outputs and upstream of data memory.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- AW, 32, byte-address width
- DW, 32, data width; fixed at 32 with 4 byte lanes

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- st_valid  in  1  store request from core (MemWrite)
- st_addr  in  AW  store byte address; bits [1:0] ignored
- st_data  in  DW  store data, already lane-aligned
- st_be  in  4  byte enables; 4'hF for STR, one-hot for STRB
- st_stall  out  1  store refused this cycle; core must hold the instruction
- ld_valid  in  1  load in progress
- ld_addr  in  AW  load byte address
- ld_fwd_be  out  4  bytes supplied by the buffer (forwarding build)
- ld_fwd_data  out  DW  forwarded bytes; lanes not in ld_fwd_be read 0
- ld_conflict  out  1  load must stall (non-forwarding build)
- mem_req  out  1  write request to memory
- mem_addr  out  AW  head entry word address, {addr[AW-1:2],2'b00}
- mem_wdata  out  DW  head entry data
- mem_be  out  4  head entry byte enables
- mem_ack  in  1  memory accepts the write on this edge
- empty  out  1  no entries held

## Operation
- Circular FIFO with head pointer, tail pointer, and count. Count width is $clog2(DEPTH+1). Pointers wrap from DEPTH-1 to 0.
- **Push:** st_valid && !full at the rising edge writes {word addr, data, be} at the tail; the tail advances.
- **Full:** count==DEPTH. st_stall = st_valid && full, combinational. A push is refused when full even if a pop occurs on the same edge.
- **Pop:** mem_req = (count!=0). The mem_* outputs reflect the head entry. On an edge where mem_req && mem_ack, the head advances.
- **Push and pop on the same edge:** count is unchanged and both pointers advance.
- **Ordering:** stores to memory are issued strictly in program order. There is no coalescing.
- **Load check:** a store hits when its word address (addr[AW-1:2]) equals ld_addr[AW-1:2] and the entry is valid. Only held entries are checked; a store arriving in the same cycle is not checked.
- With ld_valid low: ld_fwd_be=0 and ld_conflict=0.
- mem_ack while mem_req is low is ignored.

## Timing
- Push-to-mem_req latency: 1 cycle when empty.
- mem_req, mem_addr, mem_wdata and mem_be are driven from registered state only, with no combinational path from mem_ack. They stay stable until acknowledged.
- Maximum drain rate is 1 entry per cycle with mem_ack held high.
- **Reset, asynchronous:**
  - Count, head and tail return to 0.
  - Outputs go to: mem_req=0, empty=1, st_stall=0 (when st_valid=0), ld_fwd_be=0, ld_conflict=0, mem_* data=0.
  - Reset mid-request discards every entry, and mem_req drops immediately. Memory must tolerate an abandoned request.

## Configuration
- **STORE_BUF_FWD_EN defined:** per-byte forwarding is enabled.
  - For each lane, the youngest matching entry with that be bit set supplies the byte.
  - ld_fwd_be is the OR of lanes supplied.
  - ld_conflict is tied 0.
  - The core merges ld_fwd_data over memory data.
- **STORE_BUF_FWD_EN undefined:** forwarding is removed.
  - ld_fwd_be and ld_fwd_data are tied 0.
  - ld_conflict = ld_valid && any hit.
  - The core stalls until the matching entries drain.

## Structure
- store_buffer_pkg holds:
  - typedef sb_entry_t {logic [AW-1:2] waddr; logic [31:0] data; logic [3:0] be;}
  - constant SB_LANES=4
  - function lane_mask(be) expanding a 4-bit be to a 32-bit mask
- One sub-module: sb_fwd_merge. It is combinational; it takes the entry array, valid vector, head pointer and ld_addr, and produces ld_fwd_be and ld_fwd_data with age priority. It is instantiated only under STORE_BUF_FWD_EN.

## Test plan
- **Single store:** reset, st_valid 1 cycle with addr 0xF8, data 7, be F, and mem_ack tied 1.
  - Next cycle: mem_req=1, mem_addr=0xF8, mem_wdata=7.
  - Following cycle: empty=1.
- **Fill and stall:** mem_ack=0, 5 consecutive stores to 0x00, 0x04, 0x08, 0x0C, 0x10.
  - st_stall=1 only on the 5th store; count=4.
  - Raise mem_ack: writes appear in order 0x00, 0x04, 0x08, 0x0C.
- **Same-edge push/pop at count 2:** count stays 2 and the pointers wrap correctly across 3 laps (DEPTH=4).
- **Forwarding build:** mem_ack=0.
  - STRB 0xAA to 0x41, then STR 0x11223344 to 0x40, then STRB 0xBB to 0x42.
  - Load 0x40 returns ld_fwd_be=F and ld_fwd_data=0x11BB3344.
  - Non-forwarding build, same stimulus: ld_conflict=1 until the last of the three entries drains.
- **Reset mid-request:** assert reset while mem_req=1 with 3 entries held.
  - mem_req=0 and empty=1 in the same cycle.
  - No further mem_req after reset is released.
- **Spurious ack:** mem_ack=1 while empty. No pointer change and no mem_req.
